mem_arb2: RTL
=============

MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter burst_length, default 4, meaning words returned per read burst.
REQ-002 SHALL have parameter ID_A, default 1, meaning mem_id tag driven for port A.
REQ-003 SHALL have parameter ID_B, default 2, meaning mem_id tag driven for port B.
REQ-004 SHALL have port clock  input  1  sole clock; all flops posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports a_address/b_address  input  30  word address from master A/B.
REQ-007 SHALL have ports a_read, a_write/b_read, b_write  input  1  request strobes, held by master until accepted.
REQ-008 SHALL have ports a_writedata/b_writedata  input  32  and a_writedatamask/b_writedatamask  input  4  byte enables.
REQ-009 SHALL have ports a_waitrequest/b_waitrequest  output  1  high = request not accepted this cycle.
REQ-010 SHALL have ports a_readdata/b_readdata  output  32  and a_readdatavalid/b_readdatavalid  output  1  return beat.
REQ-011 SHALL have slave ports mem_waitrequest in 1; mem_id out 2; mem_address out 30; mem_read, mem_write out 1; mem_writedata out 32; mem_writedatamask out 4; mem_readdata in 32; mem_readdataid in 2 (0 = no beat).

Function
REQ-012 Port X eligible when (X_read|X_write) and outstanding counter cnt_X == 0.
REQ-013 Grant state machine states: S_IDLE, S_OWN_A, S_OWN_B.
REQ-014 S_IDLE, one port eligible: that port selected combinationally same cycle.
REQ-015 S_IDLE, both eligible: port not equal to last_grant selected (round-robin).
REQ-016 Selected port's address/read/write/writedata/mask and tag SHALL drive mem_*; unselected: mem_read = mem_write = 0, mem_id = 0.
REQ-017 Acceptance = selected request present and mem_waitrequest == 0; selected X_waitrequest = mem_waitrequest; other port waitrequest = 1.
REQ-018 Selected but not accepted (mem_waitrequest high): next state S_OWN_X; selection locked to X until accepted, regardless of other port.
REQ-019 On acceptance: last_grant <= X, state <= S_IDLE.
REQ-020 Accepted read: cnt_X <= burst_length; accepted write: cnt_X unchanged.
REQ-021 Port with cnt_X != 0: X_waitrequest = 1 for both reads and writes (ordering preserved).
REQ-022 mem_readdataid == ID_X: X_readdatavalid = 1 same cycle (combinational), cnt_X decrements.
REQ-023 a_readdata = b_readdata = mem_readdata unconditionally.
REQ-024 mem_readdataid with cnt_X == 0, or id 3: ignored; counters SHALL NOT underflow.
REQ-025 Counters width clog2(burst_length)+1; no wrap permitted.
REQ-026 Beat return and new acceptance for other port same cycle: both take effect independently.

Reset
REQ-027 rst asserted: state = S_IDLE, cnt_A = cnt_B = 0, last_grant = B (A wins first tie).
REQ-028 Outputs during reset: mem_read = mem_write = 0, mem_id = 0, both readdatavalid = 0, both waitrequest = 1.
REQ-029 Reset mid-burst: outstanding counts discarded; stray beats after reset ignored per REQ-024.

Structure
REQ-030 State encodings S_IDLE/S_OWN_A/S_OWN_B and default ID_A/ID_B SHALL live in shared package mem_pkg, reused by sram16 controller bench.
REQ-031 One sub-module natural: mem_arb_port (per-port outstanding counter + eligibility), instantiated twice.

Verification
REQ-032 Only A reads 0x100, mem_waitrequest 0 -> mem_id=1 same cycle; cnt_A=4; a_waitrequest=1 until four beats id=1 seen.
REQ-033 A and B read simultaneously after reset -> A granted first, B next cycle (mem_id 1 then 2).
REQ-034 B write 0xDEADBEEF mask 0xF, mem_waitrequest high 5 cycles, A raises read in cycle 2 -> mem_* stays on B until accepted, then A.
REQ-035 A back-to-back reads -> second read accepted only cycle after 4th id=1 beat.
REQ-036 Stray mem_readdataid=2 with cnt_B=0 -> b_readdatavalid=1 pulse, cnt_B stays 0.
REQ-037 rst asserted after 2 of 4 beats -> counters 0, a_waitrequest released next cycle after rst deasserts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared arbitration types and default slave tags for the memory front-end.
// Also reused by the sram16 controller bench.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic [1:0] ID_NONE      = 2'd0;
    localparam logic [1:0] ID_A_DEFAULT = 2'd1;
    localparam logic [1:0] ID_B_DEFAULT = 2'd2;

    // Wide enough to hold burst_length itself without wrapping.
    function automatic int cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_port.sv
// Per-master read bookkeeping: outstanding-beat counter, eligibility and
// return-beat decode for one tagged port.
module mem_arb_port
    import mem_pkg::*;
#(
    parameter int         BURST_LEN = 4,
    parameter logic [1:0] PORT_ID   = ID_A_DEFAULT
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       req_i,
    input  logic       accept_read_i,
    input  logic [1:0] beat_id_i,
    output logic       eligible_o,
    output logic       readdatavalid_o
);

    localparam int             CW        = cnt_width(BURST_LEN);
    localparam logic [CW-1:0]  BURST_CNT = CW'(BURST_LEN);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          beat;

    assign beat = (beat_id_i == PORT_ID);

    // A read is only accepted with cnt_q == 0, so load and decrement never
    // compete; beats arriving with nothing outstanding are dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_read_i) begin
            cnt_d = BURST_CNT;
        end else if (beat && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eligible_o      = req_i && (cnt_q == '0);
    assign readdatavalid_o = beat && !rst;

endmodule

// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter onto a single tagged, pipelined memory
// slave; a stalled grant stays locked until the slave accepts it.
module mem_arb2
    import mem_pkg::*;
#(
    parameter int         burst_length = 4,
    parameter logic [1:0] ID_A         = ID_A_DEFAULT,
    parameter logic [1:0] ID_B         = ID_B_DEFAULT
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [29:0] a_address,
    input  logic        a_read,
    input  logic        a_write,
    input  logic [31:0] a_writedata,
    input  logic [3:0]  a_writedatamask,
    output logic        a_waitrequest,
    output logic [31:0] a_readdata,
    output logic        a_readdatavalid,
    input  logic [29:0] b_address,
    input  logic        b_read,
    input  logic        b_write,
    input  logic [31:0] b_writedata,
    input  logic [3:0]  b_writedatamask,
    output logic        b_waitrequest,
    output logic [31:0] b_readdata,
    output logic        b_readdatavalid,
    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid
);

    arb_state_e state_q, state_d;
    port_e      last_grant_q, last_grant_d;
    logic       a_elig, b_elig, sel_a, sel_b, a_accept, b_accept;

    mem_arb_port #(.BURST_LEN(burst_length), .PORT_ID(ID_A)) u_port_a (
        .clock           (clock),
        .rst             (rst),
        .req_i           (a_read | a_write),
        .accept_read_i   (a_accept & a_read),
        .beat_id_i       (mem_readdataid),
        .eligible_o      (a_elig),
        .readdatavalid_o (a_readdatavalid)
    );

    mem_arb_port #(.BURST_LEN(burst_length), .PORT_ID(ID_B)) u_port_b (
        .clock           (clock),
        .rst             (rst),
        .req_i           (b_read | b_write),
        .accept_read_i   (b_accept & b_read),
        .beat_id_i       (mem_readdataid),
        .eligible_o      (b_elig),
        .readdatavalid_o (b_readdatavalid)
    );

    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        case (state_q)
            S_OWN_A: sel_a = 1'b1;
            S_OWN_B: sel_b = 1'b1;
            default: begin
                if (a_elig && b_elig) begin
                    sel_a = (last_grant_q == PORT_B);
                    sel_b = (last_grant_q == PORT_A);
                end else begin
                    sel_a = a_elig;
                    sel_b = b_elig;
                end
            end
        endcase
        if (rst) begin
            sel_a = 1'b0;
            sel_b = 1'b0;
        end
    end

    assign a_accept = sel_a && (a_read | a_write) && !mem_waitrequest;
    assign b_accept = sel_b && (b_read | b_write) && !mem_waitrequest;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (a_accept) begin
            state_d      = S_IDLE;
            last_grant_d = PORT_A;
        end else if (b_accept) begin
            state_d      = S_IDLE;
            last_grant_d = PORT_B;
        end else if (sel_a && mem_waitrequest) begin
            state_d = S_OWN_A;
        end else if (sel_b && mem_waitrequest) begin
            state_d = S_OWN_B;
        end
    end

    // last_grant resets to B so that A wins the first tie.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= PORT_B;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_id            = sel_a ? ID_A : (sel_b ? ID_B : ID_NONE);
    assign mem_read          = (sel_a & a_read)  | (sel_b & b_read);
    assign mem_write         = (sel_a & a_write) | (sel_b & b_write);
    assign mem_address       = sel_b ? b_address       : a_address;
    assign mem_writedata     = sel_b ? b_writedata     : a_writedata;
    assign mem_writedatamask = sel_b ? b_writedatamask : a_writedatamask;

    assign a_waitrequest = sel_a ? mem_waitrequest : 1'b1;
    assign b_waitrequest = sel_b ? mem_waitrequest : 1'b1;
    assign a_readdata    = mem_readdata;
    assign b_readdata    = mem_readdata;

endmodule
